// File: rtl/la_iopwrseq_pkg.sv
// Shared definitions for the IO-ring power sequencer.
// The 3-bit state codes are exported here so that status decoders elsewhere
// in the padring interpret the sequencer's state output identically.
package la_iopwrseq_pkg;

  localparam logic [2:0] PWR_OFF      = 3'd0;
  localparam logic [2:0] PWR_DEBOUNCE = 3'd1;
  localparam logic [2:0] PWR_UNISO    = 3'd2;
  localparam logic [2:0] PWR_STAGE    = 3'd3;
  localparam logic [2:0] PWR_READY    = 3'd4;
  localparam logic [2:0] PWR_DOWN     = 3'd5;
  localparam logic [2:0] PWR_FAULT    = 3'd6;

  typedef enum logic [2:0] {
    S_OFF      = PWR_OFF,
    S_DEBOUNCE = PWR_DEBOUNCE,
    S_UNISO    = PWR_UNISO,
    S_STAGE    = PWR_STAGE,
    S_READY    = PWR_READY,
    S_DOWN     = PWR_DOWN,
    S_FAULT    = PWR_FAULT
  } pwr_state_t;

  // Width of the stage index; a single group still needs one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/la_dsync.sv
// Two-flop synchronizer for asynchronous power-good inputs.
// Both flops clear on reset so a supply is considered bad until proven good.
module la_dsync (
  input  logic clk,
  input  logic nreset,
  input  logic din,
  output logic dout
);

  logic meta;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/la_iopwrseq.sv
// IO-ring power sequencer.
// Debounces the core and IO power-good indications, then releases isolation
// and enables pad groups one at a time, tearing them down in reverse order.
// Losing either supply forces isolation on and all pads off immediately.
module la_iopwrseq
  import la_iopwrseq_pkg::*;
#(
  parameter int NSTAGE   = 4,
  parameter int DEBOUNCE = 1000,
  parameter int SETTLE   = 64,
  parameter int CW       = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              pg_vdd,
  input  logic              pg_vddio,
  input  logic              req,
  output logic              iso,
  output logic [NSTAGE-1:0] ioen,
  output logic              ready,
  output logic              fault,
  output logic [2:0]        state
);

  localparam int IW = idx_width(NSTAGE);

  // Debounce releases on the sample after DEBOUNCE consecutive good samples,
  // so the counter compares against DEBOUNCE itself.
  localparam logic [CW-1:0]     DB_LAST  = CW'(DEBOUNCE);
  localparam logic [CW-1:0]     ST_LAST  = CW'(SETTLE - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(NSTAGE - 1);
  localparam logic [NSTAGE-1:0] IOEN_LSB = NSTAGE'(1);

  logic pg_vdd_s;
  logic pg_vddio_s;
  logic pg_ok;

  pwr_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              iso_q, iso_d;
  logic [NSTAGE-1:0] ioen_q, ioen_d;
  logic              ready_q, ready_d;
  logic              fault_q, fault_d;

  logic [CW-1:0] cnt_inc;
  logic          settled;
  logic          supply_lost;
  logic          req_dropped;

  la_dsync u_sync_vdd (
    .clk    (clk),
    .nreset (nreset),
    .din    (pg_vdd),
    .dout   (pg_vdd_s)
  );

  la_dsync u_sync_vddio (
    .clk    (clk),
    .nreset (nreset),
    .din    (pg_vddio),
    .dout   (pg_vddio_s)
  );

  assign pg_ok   = pg_vdd_s & pg_vddio_s;
  assign cnt_inc = cnt_q + CW'(1);
  assign settled = (cnt_q == ST_LAST);

  // Supply loss outranks a request drop, which outranks counter expiry.
  assign supply_lost = !pg_ok &&
                       (state_q inside {S_UNISO, S_STAGE, S_READY, S_DOWN});
  assign req_dropped = !req && (state_q inside {S_UNISO, S_STAGE, S_READY});

  // State, counters and all outputs are registered together.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      idx_q   <= '0;
      iso_q   <= 1'b1;
      ioen_q  <= '0;
      ready_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      iso_q   <= iso_d;
      ioen_q  <= ioen_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
    end
  end

  // Next-state and next-output decision; pad enables always form a
  // thermometer code from bit 0, so staging shifts a one in at the bottom
  // and teardown shifts the top set bit out.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    iso_d   = iso_q;
    ioen_d  = ioen_q;
    ready_d = ready_q;
    fault_d = fault_q;

    if (supply_lost) begin
      state_d = S_FAULT;
      cnt_d   = '0;
      idx_d   = '0;
      iso_d   = 1'b1;
      ioen_d  = '0;
      ready_d = 1'b0;
      fault_d = 1'b1;
    end else if (req_dropped) begin
      state_d = S_DOWN;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          iso_d   = 1'b1;
          ioen_d  = '0;
          ready_d = 1'b0;
          fault_d = 1'b0;
          if (req && pg_ok) begin
            state_d = S_DEBOUNCE;
            cnt_d   = '0;
            idx_d   = '0;
          end
        end
        S_DEBOUNCE: begin
          if (!req) begin
            state_d = S_OFF;
            cnt_d   = '0;
          end else if (!pg_ok) begin
            cnt_d = '0;
          end else if (cnt_q == DB_LAST) begin
            state_d = S_UNISO;
            cnt_d   = '0;
            iso_d   = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_UNISO: begin
          if (settled) begin
            state_d = S_STAGE;
            cnt_d   = '0;
            idx_d   = '0;
            ioen_d  = (ioen_q << 1) | IOEN_LSB;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_STAGE: begin
          if (settled) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_READY;
              ready_d = 1'b1;
            end else begin
              idx_d  = idx_q + IW'(1);
              ioen_d = (ioen_q << 1) | IOEN_LSB;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_READY: begin
          ready_d = 1'b1;
        end
        S_DOWN: begin
          if (settled) begin
            cnt_d = '0;
            if (|ioen_q) begin
              ioen_d = ioen_q >> 1;
            end else if (!iso_q) begin
              iso_d = 1'b1;
            end else begin
              state_d = S_OFF;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_FAULT: begin
          if (!req) begin
            state_d = S_OFF;
            cnt_d   = '0;
            fault_d = 1'b0;
          end
        end
        default: begin
          state_d = S_OFF;
          cnt_d   = '0;
          idx_d   = '0;
          iso_d   = 1'b1;
          ioen_d  = '0;
          ready_d = 1'b0;
          fault_d = 1'b0;
        end
      endcase
    end
  end

  assign iso   = iso_q;
  assign ioen  = ioen_q;
  assign ready = ready_q;
  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: tb/tb_la_iopwrseq.sv
// Self-checking bench for la_iopwrseq.
// Each scenario computes its whole expected output timeline from the edge
// formulas of the sequencer and queues one record per clock edge; a monitor
// pops and compares the record matching the current edge.
module tb_la_iopwrseq;

  localparam int D = 8;
  localparam int S = 4;
  localparam int N = 4;

  localparam logic [2:0] C_OFF   = 3'd0;
  localparam logic [2:0] C_DEB   = 3'd1;
  localparam logic [2:0] C_UNISO = 3'd2;
  localparam logic [2:0] C_STAGE = 3'd3;
  localparam logic [2:0] C_READY = 3'd4;
  localparam logic [2:0] C_DOWN  = 3'd5;
  localparam logic [2:0] C_FAULT = 3'd6;

  localparam int T_OFF = 0, T_UP = 1, T_DOWN = 2, T_FLT = 3, T_RST = 4;

  logic         clk = 1'b0;
  logic         nreset;
  logic         pg_vdd;
  logic         pg_vddio;
  logic         req;
  logic         iso;
  logic [N-1:0] ioen;
  logic         ready;
  logic         fault;
  logic [2:0]   state;

  typedef struct {
    int           e;
    logic         iso;
    logic [N-1:0] ioen;
    logic         ready;
    logic         fault;
    logic [2:0]   st;
    int           tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  la_iopwrseq #(
    .NSTAGE   (N),
    .DEBOUNCE (D),
    .SETTLE   (S),
    .CW       (16)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .pg_vdd   (pg_vdd),
    .pg_vddio (pg_vddio),
    .req      (req),
    .iso      (iso),
    .ioen     (ioen),
    .ready    (ready),
    .fault    (fault),
    .state    (state)
  );

  // Free-running sequencer clock.
  always #5 clk = ~clk;

  // Edge counter: after posedge number E, cyc reads E.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string tag_name(input int t);
    case (t)
      T_OFF:   return "idle_off";
      T_UP:    return "powerup";
      T_DOWN:  return "teardown";
      T_FLT:   return "fault";
      T_RST:   return "reset";
      default: return "other";
    endcase
  endfunction

  function automatic logic [N-1:0] therm(input int m);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) if (k < m) v[k] = 1'b1;
    return v;
  endfunction

  // Number of pad groups enabled after edge e, given UNISO was entered at tu.
  function automatic int bits_at(input int tu, input int e);
    int nb;
    nb = 0;
    for (int k = 0; k < N; k++) if (e >= tu + S * (k + 1)) nb++;
    return nb;
  endfunction

  task automatic check_output(input int tg, input int e, input logic ei,
                              input logic [N-1:0] eio, input logic er,
                              input logic ef, input logic [2:0] es);
    checks++;
    if ({iso, ioen, ready, fault, state} !== {ei, eio, er, ef, es}) begin
      fails++;
      $display("[TB] FAIL %s edge %0d: got iso=%b ioen=%b ready=%b fault=%b state=%0d, expected iso=%b ioen=%b ready=%b fault=%b state=%0d",
               tag_name(tg), e, iso, ioen, ready, fault, state, ei, eio, er, ef, es);
    end
  endtask

  task automatic push(input int e, input logic i, input logic [N-1:0] io,
                      input logic r, input logic f, input logic [2:0] s,
                      input int tg);
    exp_t x;
    x.e = e; x.iso = i; x.ioen = io; x.ready = r; x.fault = f; x.st = s; x.tag = tg;
    sb.push_back(x);
  endtask

  // Monitor: compare the DUT against the record for the current edge.
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].e <= cyc) begin
      x = sb.pop_front();
      if (x.e < cyc) begin
        checks++;
        fails++;
        $display("[TB] FAIL stale_record: record for edge %0d reached at edge %0d", x.e, cyc);
      end else begin
        check_output(x.tag, x.e, x.iso, x.ioen, x.ready, x.fault, x.st);
      end
    end
  end

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    int c;
    c = cyc;
    for (int i = 1; i <= n; i++) push(c + i, 1'b1, '0, 1'b0, 1'b0, C_OFF, T_OFF);
    wait_until(c + n);
  endtask

  // Power-up expectations: request sampled at e0, debounce (re)started at a.
  task automatic exp_powerup(input int e0, input int a, input int last);
    int tu;
    int nb;
    tu = a + 1 + D;
    for (int e = e0; e <= last; e++) begin
      if (e < tu) begin
        push(e, 1'b1, '0, 1'b0, 1'b0, C_DEB, T_UP);
      end else begin
        nb = bits_at(tu, e);
        if (e >= tu + S * (N + 1))
          push(e, 1'b0, therm(nb), 1'b1, 1'b0, C_READY, T_UP);
        else if (e >= tu + S)
          push(e, 1'b0, therm(nb), 1'b0, 1'b0, C_STAGE, T_UP);
        else
          push(e, 1'b0, therm(nb), 1'b0, 1'b0, C_UNISO, T_UP);
      end
    end
  endtask

  // Teardown expectations from drop edge t with m groups enabled.
  task automatic exp_teardown(input int t, input int m);
    int j;
    for (int e = t; e <= t + (m + 2) * S; e++) begin
      j = (e - t) / S;
      if (j <= m)
        push(e, 1'b0, therm(m - j), 1'b0, 1'b0, C_DOWN, T_DOWN);
      else if (j == m + 1)
        push(e, 1'b1, '0, 1'b0, 1'b0, C_DOWN, T_DOWN);
      else
        push(e, 1'b1, '0, 1'b0, 1'b0, C_OFF, T_DOWN);
    end
  endtask

  // One power-up followed by either a teardown (act=0) or a supply loss (act=1)
  // at delta edges after isolation release; gk>0 glitches pg_vddio so that the
  // sequencer sees it low gk edges into debounce.
  task automatic apply_stimulus(input int gk, input int act, input int delta,
                                input bit reassert);
    int c, e0, a, tu, t, m, oe, ft, he, ra;
    c  = cyc;
    e0 = c + 1;
    a  = (gk > 0) ? e0 + gk : e0;
    tu = a + 1 + D;
    req = 1'b1;
    if (act == 0) begin
      t  = tu + delta;
      m  = bits_at(tu, t - 1);
      oe = t + (m + 2) * S;
      exp_powerup(e0, a, t - 1);
      exp_teardown(t, m);
      if (gk > 0) begin
        wait_until(a - 3); pg_vddio = 1'b0;
        wait_until(a - 2); pg_vddio = 1'b1;
      end
      wait_until(t - 1);
      req = 1'b0;
      if (reassert) begin
        ra = t + $urandom_range(0, oe - 2 - t);
        wait_until(ra);
        req = 1'b1;
        wait_until(oe - 1);
        req = 1'b0;
      end
      wait_until(oe);
    end else begin
      ft = tu + delta;
      he = ft + $urandom_range(2, 6);
      exp_powerup(e0, a, ft - 1);
      for (int e = ft; e <= he; e++) push(e, 1'b1, '0, 1'b0, 1'b1, C_FAULT, T_FLT);
      for (int e = he + 1; e <= he + 4; e++) push(e, 1'b1, '0, 1'b0, 1'b0, C_OFF, T_FLT);
      if (gk > 0) begin
        wait_until(a - 3); pg_vddio = 1'b0;
        wait_until(a - 2); pg_vddio = 1'b1;
      end
      wait_until(ft - 3);
      pg_vdd = 1'b0;
      wait_until(he);
      req = 1'b0;
      wait_until(he + 1);
      pg_vdd = 1'b1;
      wait_until(he + 4);
    end
  endtask

  // Power up, then pull nreset low mid-cycle while staging pad groups.
  task automatic reset_in_stage();
    int c, e0, tu, x;
    c  = cyc;
    e0 = c + 1;
    tu = e0 + 1 + D;
    x  = tu + S + 1 + $urandom_range(0, 2 * S);
    exp_powerup(e0, e0, x - 1);
    for (int e = x; e <= x + 3; e++) push(e, 1'b1, '0, 1'b0, 1'b0, C_OFF, T_RST);
    req = 1'b1;
    wait_until(x);
    #2;
    nreset = 1'b0;
    #1;
    check_output(T_RST, x, 1'b1, '0, 1'b0, 1'b0, C_OFF);
    req = 1'b0;
    wait_until(x + 3);
    nreset = 1'b1;
  endtask

  // Main stimulus sequence.
  initial begin
    nreset   = 1'b0;
    pg_vdd   = 1'b1;
    pg_vddio = 1'b1;
    req      = 1'b0;
    #12;
    check_output(T_RST, cyc, 1'b1, '0, 1'b0, 1'b0, C_OFF);
    wait_until(3);
    nreset = 1'b1;
    idle(5);

    apply_stimulus(0, 0, S * (N + 1) + 2, 1'b0);
    idle(5);
    apply_stimulus(5, 1, S * (N + 1) + 3, 1'b0);
    idle(5);
    apply_stimulus(0, 0, 2 * S + 2, 1'b1);
    idle(5);
    reset_in_stage();
    idle(5);

    for (int it = 0; it < 12; it++) begin
      int gk, act, delta;
      bit rs;
      gk    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, D - 1)) : 0;
      act   = $urandom_range(0, 1);
      delta = $urandom_range(1, S * (N + 1) + 5);
      rs    = 1'($urandom_range(0, 1));
      apply_stimulus(gk, act, delta, rs);
      idle($urandom_range(4, 8));
    end

    idle(3);
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain: %0d records left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
